// File: rtl/dac_sample_fifo_pkg.sv
// Shared constants for the DAC sample path: frame width, stereo channel
// field positions and underrun counter width.
package dac_sample_fifo_pkg;

  localparam int SAMPLE_W   = 32;
  localparam int LEFT_MSB   = 31;
  localparam int LEFT_LSB   = 16;
  localparam int RIGHT_MSB  = 15;
  localparam int RIGHT_LSB  = 0;
  localparam int UNDERRUN_W = 16;

  // Packs one stereo frame the way the codec controller shifts it out.
  function automatic logic [SAMPLE_W-1:0] make_frame(
    input logic [LEFT_MSB-LEFT_LSB:0]   left,
    input logic [RIGHT_MSB-RIGHT_LSB:0] right
  );
    logic [SAMPLE_W-1:0] f;
    f = '0;
    f[LEFT_MSB:LEFT_LSB]   = left;
    f[RIGHT_MSB:RIGHT_LSB] = right;
    return f;
  endfunction

endpackage

// File: rtl/dac_fifo_mem.sv
// Sample frame storage: synchronous write port, asynchronous read port so
// the prefetch register can load the head entry in the same cycle it pops.
module dac_fifo_mem #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/dac_sample_fifo.sv
// Stereo DAC frame FIFO with a prefetch output register that the codec
// controller samples on its frame-load strobe; counts strobes that find no data.
module dac_sample_fifo
  import dac_sample_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = SAMPLE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    load_strobe,
  output logic [DATA_W-1:0]       dac_data,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic [DEPTH_LOG2:0]     level,
  input  logic                    underrun_clr,
  output logic [UNDERRUN_W-1:0]   underrun_cnt
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     dac_data_q, dac_data_d;
  logic [UNDERRUN_W-1:0] underrun_cnt_q, underrun_cnt_d;

  logic              wr_fire;
  logic              pop;
  logic [DATA_W-1:0] mem_rd_data;

  assign wr_ready = !reset && (count_q != DEPTH_CNT);
  assign wr_fire  = wr_valid && wr_ready;
  // Refill the output register when it is empty or being consumed this cycle.
  assign pop      = (count_q != '0) && (!out_valid_q || load_strobe);

  dac_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    out_valid_d    = out_valid_q;
    dac_data_d     = dac_data_q;
    underrun_cnt_d = underrun_cnt_q;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      dac_data_d  = mem_rd_data;
      out_valid_d = 1'b1;
    end else if (load_strobe) begin
      // Nothing ready for the next frame: present silence.
      dac_data_d  = '0;
      out_valid_d = 1'b0;
    end

    case ({wr_fire, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (underrun_clr) begin
      underrun_cnt_d = '0;
    end else if (load_strobe && !out_valid_q && (underrun_cnt_q != '1)) begin
      underrun_cnt_d = underrun_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      dac_data_q     <= '0;
      underrun_cnt_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      dac_data_q     <= dac_data_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign dac_data     = dac_data_q;
  assign underrun_cnt = underrun_cnt_q;
  assign fifo_empty   = (count_q == '0) && !out_valid_q;
  assign fifo_full    = (count_q == DEPTH_CNT);
  assign level        = count_q + {{DEPTH_LOG2{1'b0}}, out_valid_q};

endmodule

// File: doc/dac_sample_fifo.md
Name: dac_sample_fifo

Overview:
- Buffers stereo DAC samples between the system-side producer and the codec serial controller.
- Delivers one 32-bit frame per codec frame strobe: {left[31:16], right[15:0]}.
- The output register feeds the controller's dac_data_in directly.
- The load_strobe input is the controller's frame-load pulse (flancadcclk).
- fifo_empty feeds the controller's dac_fifo_empty.

Parameters:
- DEPTH_LOG2, 4, log2 of memory depth (DEPTH = 16 entries).
- DATA_W, 32, sample frame width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- wr_data  in  DATA_W  sample frame from producer
- wr_valid  in  1  producer has a frame
- wr_ready  out  1  block accepts the frame this cycle
- load_strobe  in  1  one-cycle pulse; the controller captures dac_data in this same cycle
- dac_data  out  DATA_W  registered frame presented to the controller
- fifo_empty  out  1  no frame in memory and no valid frame in dac_data
- fifo_full  out  1  memory holds DEPTH entries
- level  out  DEPTH_LOG2+1  memory count + out_valid (range 0..DEPTH+1)
- underrun_clr  in  1  clear underrun counter
- underrun_cnt  out  16  saturating count of strobes that found no valid frame

Behaviour:
- Clocking and reset: clock clk. reset is synchronous, active-high.
- Reset values:
  - wr_ptr, rd_ptr, count = 0; out_valid = 0.
  - dac_data = 0, underrun_cnt = 0.
  - fifo_empty = 1, fifo_full = 0, level = 0.
  - wr_ready = 0 while reset is high.
  - Memory contents are not reset.
- Reset mid-operation discards all queued frames. The next strobe after reset outputs zeros and counts an underrun.
- Write: wr_ready = !reset && (count != DEPTH), combinational.
  - An accepted write (wr_valid && wr_ready) stores into mem[wr_ptr], and wr_ptr increments.
  - wr_ptr wraps modulo DEPTH; its width is DEPTH_LOG2.
  - A write while full is not accepted and is not an error; the producer holds.
- Pop condition: pop = (count != 0) && (!out_valid || load_strobe).
  - On pop: dac_data <= mem[rd_ptr], out_valid <= 1, and rd_ptr increments (wraps).
- Strobe without pop: dac_data <= 0 and out_valid <= 0.
  - The controller therefore transmits silence on the following frame if no data arrives in time.
- Underrun: load_strobe while out_valid == 0 increments underrun_cnt. The controller captured a zero frame.
  - underrun_cnt saturates at 16'hFFFF.
  - underrun_clr has priority over a same-cycle increment; the result is 0.
- Count update: count += accepted write − pop. A simultaneous write and pop leaves count unchanged.
- Latency: a write accepted in cycle t enters memory at t+1.
  - count becomes nonzero at t+1; pop occurs at t+1 if out_valid == 0.
  - dac_data is valid at t+2.
  - There is no write-to-output bypass.
- A pop reads only entries written in earlier cycles. Read and write addresses can only coincide when count == 0 or count == DEPTH, and neither case pops and writes the same entry. Read-during-write ordering is therefore irrelevant.
- Flag and level outputs:
  - fifo_empty = (count == 0) && !out_valid.
  - fifo_full = (count == DEPTH).
  - level = count + out_valid.
  - All are derived from registered state.
- load_strobe arriving in back-to-back cycles is legal: each cycle pops one frame if one is available.

Decomposition:
- Shared package:
  - SAMPLE_W = 32.
  - Channel field positions: LEFT_MSB = 31, LEFT_LSB = 16, RIGHT_MSB = 15, RIGHT_LSB = 0.
  - UNDERRUN_W = 16.
- One sub-module: dac_fifo_mem. Simple dual-port RAM, DEPTH x DATA_W, synchronous write, asynchronous read at rd_ptr.
- Pointer, count, prefetch register and underrun logic stay in dac_sample_fifo.

Test Plan:
1. Reset, then write 32'h1111_2222. At t+1 count = 1; at t+2 dac_data = 32'h1111_2222, level = 1, fifo_empty = 0, count = 0.
2. Write 17 frames 0..16 with no strobes. Frame 0 is in dac_data and frames 1..16 are in memory. Expect level = 17, fifo_full = 1, wr_ready = 0. An 18th write is held: no pointer change and no data loss.
3. Full FIFO, issue 17 strobes 4 cycles apart. The dac_data sequence captured at each strobe is 0,1,...,16. After the last strobe: dac_data = 0, fifo_empty = 1, underrun_cnt = 0.
4. Empty FIFO, issue 3 strobes. Expect dac_data = 0 at each strobe and underrun_cnt = 3. Assert underrun_clr with a strobe in the same cycle: underrun_cnt = 0.
5. Simultaneous write and strobe with count = 1: count stays 1 and pointers both advance. Then wrap the pointers through 40 frames with a continuous 1:1 write/strobe rate. No underruns and in-order data.
6. Reset asserted with level = 5. Next cycle: level = 0, dac_data = 0, wr_ready = 0 during reset. After release the first strobe counts an underrun: underrun_cnt = 1.
